// File: rtl/div_sched_pkg.sv
// Shared types and sizes for the divided-tick scheduler.
package div_sched_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int DIV_W = 12;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin picker; the slot after last_i has top priority.
module rr_arb4
  import div_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the best candidate lands last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_i + IDX_W'(k);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Grants one requester at a time a burst of divided-clock ticks,
// then pulses done and rotates priority.
module div_sched
  import div_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] div_val,
  input  logic [NREQ*CNT_W-1:0] cnt_val,
  output logic [NREQ-1:0]       gnt,
  output logic                  tick,
  output logic [IDX_W-1:0]      tick_id,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lat_q, div_lat_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             tick_q, tick_d;
  logic [IDX_W-1:0] tid_q, tid_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic [DIV_W-1:0] div_a [NREQ];
  logic [CNT_W-1:0] cnt_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign div_a[i] = div_val[i*DIV_W +: DIV_W];
    assign cnt_a[i] = cnt_val[i*CNT_W +: CNT_W];
  end

  rr_arb4 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    div_cnt_d = div_cnt_q;
    div_lat_d = div_lat_q;
    left_d    = left_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_lat_d = div_a[idx_q];
        left_d    = cnt_a[idx_q];
        div_cnt_d = '0;
        state_d   = (cnt_a[idx_q] == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (!req[idx_q]) begin
          state_d = S_DONE;
        end else if (div_cnt_q == div_lat_q) begin
          div_cnt_d = '0;
          left_d    = left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) state_d = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        last_d  = idx_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from next-state values so they line up
    // with the cycle whose state they describe.
    tick_d = (state_d == S_RUN) && (div_cnt_d == div_lat_d);
    done_d = (state_d == S_DONE) ? gnt_d : '0;
    busy_d = (state_d != S_IDLE);
    tid_d  = (state_d != S_IDLE) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NREQ-1);
      div_cnt_q <= '0;
      div_lat_q <= '0;
      left_q    <= '0;
      tick_q    <= 1'b0;
      tid_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      left_q    <= left_d;
      tick_q    <= tick_d;
      tid_q     <= tid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign tick    = tick_q;
  assign tick_id = tid_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
